// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
//   Shared constants for the system-ID / housekeeping register block.
//   - Register word addresses on the Avalon-MM slave port.
//   - Bit positions inside the CTRL register.
//   - Data-path width of the bus.
// -----------------------------------------------------------------------------
package sysid_pkg;

   localparam int DATA_W = 32;

   // Word addresses
   localparam int ADDR_ID       = 0;
   localparam int ADDR_TS       = 1;
   localparam int ADDR_UP_LO    = 2;
   localparam int ADDR_UP_HI    = 3;
   localparam int ADDR_CTRL     = 4;
   localparam int ADDR_SCRATCH0 = 5;

   // CTRL register bits
   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_CLR_BIT = 1;

endpackage : sysid_pkg

// File: rtl/sysid_uptime_counter.sv
// -----------------------------------------------------------------------------
// sysid_uptime_counter
//   64-bit free-running uptime counter with word loads, clear and a snapshot
//   register for coherent hi/lo reads.
//
//   Build option: SYSID_PRESCALE_EN
//     defined   -> an internal divider produces one tick every PRESCALE_DIV
//                  clocks; the divider is cleared by reset and clr, and is
//                  frozen while en=0.
//     undefined -> the counter ticks on every clock while en=1.
//
//   Ports
//     clock, reset_n  : clock, asynchronous active-low reset
//     en              : counting enable (CTRL.EN)
//     clr             : zero the counter (and divider) at the next edge
//     load_lo/load_hi : load load_data into count[31:0] / count[63:32]
//     load_data       : data for word loads
//     snap_req        : capture count[63:32] into snapshot (LO read)
//     count_lo        : live count[31:0]
//     snapshot        : upper half captured at the last LO read
// -----------------------------------------------------------------------------
module sysid_uptime_counter
   import sysid_pkg::*;
#(
   parameter int PRESCALE_DIV = 50
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              en,
   input  logic              clr,
   input  logic              load_lo,
   input  logic              load_hi,
   input  logic [DATA_W-1:0] load_data,
   input  logic              snap_req,
   output logic [DATA_W-1:0] count_lo,
   output logic [DATA_W-1:0] snapshot
);

`ifdef SYSID_PRESCALE_EN
   localparam bit PRESCALE_EN = 1'b1;
`else
   localparam bit PRESCALE_EN = 1'b0;
`endif

   // Effective divide ratio; 1 means "tick every enabled clock".
   localparam int DIV = PRESCALE_EN ? PRESCALE_DIV : 1;

   logic                  tick;
   logic [2*DATA_W-1:0]   count;

   generate
      if (DIV > 1) begin : g_prescale
         localparam int            DW       = $clog2(DIV);
         localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

         logic [DW-1:0] div_cnt;

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               div_cnt <= '0;
            end else if (clr) begin
               div_cnt <= '0;
            end else if (en) begin
               div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
            end
         end

         assign tick = en && (div_cnt == DIV_LAST);
      end else begin : g_no_prescale
         assign tick = en;
      end
   endgenerate

   // Priority: clear, then word load, then increment. A load in a tick
   // cycle takes the written value with no increment. The 64-bit add keeps
   // the lo->hi carry inside the same cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (load_lo) begin
         count[DATA_W-1:0] <= load_data;
      end else if (load_hi) begin
         count[2*DATA_W-1:DATA_W] <= load_data;
      end else if (tick) begin
         count <= count + (2*DATA_W)'(1);
      end
   end

   // Captures the registered (pre-edge) upper half, so a concurrent HI
   // load never leaks into the snapshot of the same LO read.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         snapshot <= '0;
      end else if (snap_req) begin
         snapshot <= count[2*DATA_W-1:DATA_W];
      end
   end

   assign count_lo = count[DATA_W-1:0];

endmodule : sysid_uptime_counter

// File: rtl/sysid_regs_avmm.sv
// -----------------------------------------------------------------------------
// sysid_regs_avmm
//   System-ID and housekeeping registers on an Avalon-MM slave port.
//
//   Map (word address): 0 ID (RO), 1 TIMESTAMP (RO), 2 UPTIME_LO (RW),
//   3 UPTIME_HI (RW, reads the snapshot taken by the last LO read),
//   4 CTRL (bit0 EN RW, bit1 CLR write-1 self-clearing), 5.. scratch words
//   (RW, byte-enabled). Unmapped reads return 0, unmapped writes are dropped.
//
//   Bus handshake: there is no waitrequest, so every read/write is accepted
//   in the cycle it is presented. A read presented in cycle N returns
//   readdatavalid=1 in cycle N+1 with data sampled in cycle N; back-to-back
//   reads give back-to-back valids. A read and write in the same cycle
//   return the pre-write value while the write commits.
//
//   Build option: SYSID_PRESCALE_EN (see sysid_uptime_counter).
//
//   Ports
//     clock, reset_n        : clock, asynchronous active-low reset
//     address               : word address
//     read, write           : access strobes
//     writedata, byteenable : write data and byte lanes (scratch only)
//     readdata              : registered read data
//     readdatavalid         : one-cycle pulse qualifying readdata
// -----------------------------------------------------------------------------
module sysid_regs_avmm
   import sysid_pkg::*;
#(
   parameter logic [DATA_W-1:0] ID_VALUE     = 32'h5801_2555,
   parameter logic [DATA_W-1:0] TIMESTAMP    = 32'h0000_0000,
   parameter int                NUM_SCRATCH  = 2,
   parameter int                ADDR_W       = 3,
   parameter int                PRESCALE_DIV = 50
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   address,
   input  logic                read,
   input  logic                write,
   input  logic [DATA_W-1:0]   writedata,
   input  logic [3:0]          byteenable,
   output logic [DATA_W-1:0]   readdata,
   output logic                readdatavalid
);

   logic              ctrl_en;
   logic              wr_lo;
   logic              wr_hi;
   logic              wr_ctrl;
   logic              clr;
   logic              rd_lo;
   logic [DATA_W-1:0] count_lo;
   logic [DATA_W-1:0] snapshot;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] scratch [NUM_SCRATCH];

   assign wr_lo   = write && (address == ADDR_W'(ADDR_UP_LO));
   assign wr_hi   = write && (address == ADDR_W'(ADDR_UP_HI));
   assign wr_ctrl = write && (address == ADDR_W'(ADDR_CTRL));
   assign clr     = wr_ctrl && writedata[CTRL_CLR_BIT];
   assign rd_lo   = read && (address == ADDR_W'(ADDR_UP_LO));

   sysid_uptime_counter #(
      .PRESCALE_DIV (PRESCALE_DIV)
   ) u_uptime (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (ctrl_en),
      .clr       (clr),
      .load_lo   (wr_lo),
      .load_hi   (wr_hi),
      .load_data (writedata),
      .snap_req  (rd_lo),
      .count_lo  (count_lo),
      .snapshot  (snapshot)
   );

   // CTRL.EN; non-scratch registers take the whole word regardless of
   // byteenable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en <= 1'b1;
      end else if (wr_ctrl) begin
         ctrl_en <= writedata[CTRL_EN_BIT];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch[i] <= '0;
         end
      end else if (write) begin
         for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == ADDR_W'(ADDR_SCRATCH0 + i)) begin
               for (int b = 0; b < 4; b++) begin
                  if (byteenable[b]) begin
                     scratch[i][8*b +: 8] <= writedata[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Read mux works on registered state only, which gives the pre-write
   // value for a simultaneous read/write.
   always_comb begin
      rd_data = '0;
      if (address == ADDR_W'(ADDR_ID)) begin
         rd_data = ID_VALUE;
      end else if (address == ADDR_W'(ADDR_TS)) begin
         rd_data = TIMESTAMP;
      end else if (address == ADDR_W'(ADDR_UP_LO)) begin
         rd_data = count_lo;
      end else if (address == ADDR_W'(ADDR_UP_HI)) begin
         rd_data = snapshot;
      end else if (address == ADDR_W'(ADDR_CTRL)) begin
         rd_data[CTRL_EN_BIT] = ctrl_en;
      end
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (address == ADDR_W'(ADDR_SCRATCH0 + i)) begin
            rd_data = scratch[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         readdata      <= '0;
         readdatavalid <= 1'b0;
      end else begin
         readdatavalid <= read;
         if (read) begin
            readdata <= rd_data;
         end
      end
   end

endmodule : sysid_regs_avmm

// File: tb/tb_sysid_regs_avmm.sv
// -----------------------------------------------------------------------------
// tb_sysid_regs_avmm
//   Directed bench for sysid_regs_avmm. Read tasks push the expected word
//   (plus an allowed upward tolerance) into exp_q/tol_q; a negedge monitor
//   pops and compares whenever readdatavalid is high, and also checks that
//   readdatavalid follows each read by exactly one cycle.
// -----------------------------------------------------------------------------
module tb_sysid_regs_avmm;

   localparam int          ADDR_W    = 3;
   localparam int          W         = 32;
   localparam logic [31:0] ID_VAL    = 32'h5801_2555;
   localparam logic [31:0] TS_VAL    = 32'h6502_A1B0;

   logic              clock;
   logic              reset_n;
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [W-1:0]      writedata;
   logic [3:0]        byteenable;
   logic [W-1:0]      readdata;
   logic              readdatavalid;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] tol_q[$];
   int           checks;
   int           failures;
   logic         rd_pend;

   sysid_regs_avmm #(
      .ID_VALUE     (ID_VAL),
      .TIMESTAMP    (TS_VAL),
      .NUM_SCRATCH  (2),
      .ADDR_W       (ADDR_W),
      .PRESCALE_DIV (50)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .readdata      (readdata),
      .readdatavalid (readdatavalid)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Bench-side expectation of when readdatavalid must be high.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) rd_pend <= 1'b0;
      else          rd_pend <= read;
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      logic [W-1:0] e;
      logic [W-1:0] t;
      if (reset_n) begin
         if (readdatavalid || rd_pend) begin
            checks++;
            if (readdatavalid !== rd_pend) begin
               failures++;
               $display("FAIL valid_timing: readdatavalid=%b required=%b at %0t",
                        readdatavalid, rd_pend, $time);
            end
         end
         if (readdatavalid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_valid: readdata=%h with nothing expected at %0t",
                        readdata, $time);
            end else begin
               e = exp_q.pop_front();
               t = tol_q.pop_front();
               if ((readdata < e) || ((readdata - e) > t)) begin
                  failures++;
                  $display("FAIL read_data: got=%h required=%h (+%0d) at %0t",
                           readdata, e, t, $time);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic bus_rd(input logic [ADDR_W-1:0] a, input logic [W-1:0] e,
                         input logic [W-1:0] t);
      address = a; read = 1'b1; write = 1'b0;
      exp_q.push_back(e);
      tol_q.push_back(t);
      @(posedge clock); #1;
      read = 1'b0;
   endtask

   task automatic bus_wr(input logic [ADDR_W-1:0] a, input logic [W-1:0] d,
                         input logic [3:0] be);
      address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
      @(posedge clock); #1;
      write = 1'b0;
   endtask

   task automatic bus_rw(input logic [ADDR_W-1:0] a, input logic [W-1:0] d,
                         input logic [3:0] be, input logic [W-1:0] e);
      address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b1;
      exp_q.push_back(e);
      tol_q.push_back('0);
      @(posedge clock); #1;
      write = 1'b0; read = 1'b0;
   endtask

   task automatic idle(input int n);
      read = 1'b0; write = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain_%s: %0d reads still outstanding, required 0", tag, exp_q.size());
         exp_q.delete();
         tol_q.delete();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks = 0; failures = 0;
      reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0;
      writedata = '0; byteenable = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      checks += 2;
      if (readdata !== '0) begin
         failures++; $display("FAIL reset_readdata: got=%h required=0", readdata);
      end
      if (readdatavalid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got=%b required=0", readdatavalid);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;

      // ID then TIMESTAMP back to back; no valid in the read cycle itself.
      address = 3'd0; read = 1'b1;
      exp_q.push_back(ID_VAL); tol_q.push_back('0);
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b0) begin
         failures++; $display("FAIL valid_in_read_cycle: got=%b required=0", readdatavalid);
      end
      @(posedge clock); #1;
      bus_rd(3'd1, TS_VAL, 0);

      // Byte-enabled scratch writes, simultaneous read/write.
      bus_wr(3'd5, 32'hDEAD_BEEF, 4'b0011);
      bus_rd(3'd5, 32'h0000_BEEF, 0);
      bus_wr(3'd5, 32'h1234_0000, 4'b1100);
      bus_rd(3'd5, 32'h1234_BEEF, 0);
      bus_wr(3'd6, 32'hA5A5_5A5A, 4'b1111);
      bus_rw(3'd6, 32'h0F0F_0F0F, 4'b1111, 32'hA5A5_5A5A);
      bus_rd(3'd6, 32'h0F0F_0F0F, 0);

`ifndef SYSID_PRESCALE_EN
      // Carry across the lo/hi boundary and coherent HI snapshot.
      bus_wr(3'd3, 32'h0, 4'b1111);
      bus_wr(3'd2, 32'hFFFF_FFFE, 4'b1111);
      bus_wr(3'd4, 32'h1, 4'b1111);           // -> 0x0_FFFFFFFF
      idle(4);                                // -> 0x1_00000003
      bus_rd(3'd2, 32'h0000_0003, 0);
      bus_rd(3'd3, 32'h0000_0001, 0);
      bus_wr(3'd3, 32'h0000_0055, 4'b0001);   // lo holds at 5
      bus_rd(3'd3, 32'h0000_0001, 0);         // snapshot untouched; lo -> 6
      // Disable (byteenable ignored); the edge of this write still counts.
      bus_wr(3'd4, 32'h0, 4'b0000);           // lo -> 7, then frozen
      bus_rd(3'd2, 32'h0000_0007, 0);
      idle(10);
      bus_rd(3'd2, 32'h0000_0007, 0);
      bus_rd(3'd3, 32'h0000_0055, 0);
      // Clear and enable together.
      bus_wr(3'd4, 32'h3, 4'b1111);
      bus_rd(3'd2, 32'h0000_0000, 0);
      idle(2);
      bus_rd(3'd2, 32'h0000_0003, 0);
`else
      // One tick per 50 clocks after clear: 500 clocks -> 10 (+/-1).
      bus_wr(3'd4, 32'h3, 4'b1111);
      idle(500);
      bus_rd(3'd2, 32'd9, 2);
`endif
      bus_rd(3'd4, 32'h0000_0001, 0);         // EN=1, CLR reads 0

      // Unmapped address.
      bus_rd(3'd7, 32'h0, 0);
      bus_wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
      bus_rd(3'd5, 32'h1234_BEEF, 0);
      bus_rd(3'd6, 32'h0F0F_0F0F, 0);
      bus_rd(3'd4, 32'h0000_0001, 0);
      bus_rd(3'd0, ID_VAL, 0);
      drain("main");

      // Reset asserted during a read cycle: no valid may follow.
      address = 3'd0; read = 1'b1; reset_n = 1'b0;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b0) begin
         failures++; $display("FAIL reset_mid_read_a: valid=%b required=0", readdatavalid);
      end
      @(posedge clock); #1;
      read = 1'b0;
      @(negedge clock);
      checks++;
      if (readdatavalid !== 1'b0) begin
         failures++; $display("FAIL reset_mid_read_b: valid=%b required=0", readdatavalid);
      end
      @(posedge clock); #1;
      reset_n = 1'b1;

      // Everything back at reset values.
      bus_rd(3'd0, ID_VAL, 0);
      bus_rd(3'd5, 32'h0, 0);
      bus_rd(3'd6, 32'h0, 0);
      bus_rd(3'd4, 32'h0000_0001, 0);
      bus_rd(3'd3, 32'h0, 0);
`ifndef SYSID_PRESCALE_EN
      bus_rd(3'd2, 32'h0000_0005, 0);
`else
      bus_rd(3'd2, 32'h0000_0000, 0);
`endif
      drain("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sysid_regs_avmm

// File: doc/sysid_regs_avmm.md
Name: sysid_regs_avmm

Overview:
- Parametrised system-ID and housekeeping register block on an Avalon-MM slave port. It sits on the Nios II data bus beside other peripherals.
- Provides:
  - a read-only ID and build timestamp;
  - a 64-bit free-running uptime counter with coherent hi/lo reads;
  - a control register;
  - NUM_SCRATCH read/write scratch words.
- Software uses it to confirm it is talking to the matching hardware build and to timestamp events.

Parameters:
- ID_VALUE, 32'h5801_2555, value returned at the ID register.
- TIMESTAMP, 32'h0000_0000, build timestamp, seconds since epoch.
- NUM_SCRATCH, 2, number of 32-bit scratch registers, range 1..3.
- ADDR_W, 3, word-address width. Must cover 5+NUM_SCRATCH words.
- PRESCALE_DIV, 50, uptime tick divisor. Used only with SYSID_PRESCALE_EN.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes
- readdata  out  32  registered read data
- readdatavalid  out  1  one-cycle pulse qualifying readdata

Behaviour:
- Reset:
  - Asynchronous assert; synchronous use after deassert.
  - readdata=0, readdatavalid=0, uptime=0, snapshot=0, scratch=0, CTRL.EN=1.
  - Reset mid-read drops the pending readdatavalid.
- Bus protocol:
  - No waitrequest; every access is accepted in the cycle it is presented.
  - Read latency is exactly 1. readdatavalid rises the cycle after read=1 and carries data sampled in the read cycle.
  - Back-to-back reads give back-to-back valids.
  - read and write in the same cycle: the write commits and the read returns the pre-write value.
- Register map (word address):
  - 0 ID: RO, ID_VALUE.
  - 1 TIMESTAMP: RO.
  - 2 UPTIME_LO: RW.
    - Read returns counter[31:0] and copies counter[63:32] into the snapshot register in the same cycle.
    - Write loads counter[31:0]; upper half unchanged.
  - 3 UPTIME_HI: RW.
    - Read returns the snapshot, not the live upper half.
    - Write loads counter[63:32].
  - 4 CTRL:
    - bit0 EN: RW. Counting is enabled when 1.
    - bit1 CLR: write 1 zeroes the counter in the next cycle; reads as 0.
    - Other bits read 0.
  - 5..4+NUM_SCRATCH SCRATCH: RW, byteenable-qualified per byte.
  - Unmapped: reads return 0; writes are ignored.
- Non-scratch registers ignore byteenable; a write updates the whole word.
- Counter:
  - Increments by 1 per tick when EN=1 and wraps 2^64-1 -> 0.
  - Carry from lo to hi occurs in the same cycle.
  - Priority, highest first: CLR, then load-by-write, then increment.
  - A write to LO/HI in a tick cycle loads the written value with no increment that cycle.
- A read of UPTIME_LO in the same cycle as a write to UPTIME_HI snapshots the pre-write upper half.

Optional Feature:
- SYSID_PRESCALE_EN defined:
  - An internal divider generates a tick every PRESCALE_DIV clocks; the uptime counter advances on ticks only.
  - The divider resets to 0 on reset_n and on CLR.
  - The divider is frozen while EN=0.
- Not defined: tick = every clock; PRESCALE_DIV is unused.

Decomposition:
- Package sysid_pkg:
  - Register word-address constants: ADDR_ID, ADDR_TS, ADDR_UP_LO, ADDR_UP_HI, ADDR_CTRL, ADDR_SCRATCH0.
  - CTRL bit indices: CTRL_EN_BIT, CTRL_CLR_BIT.
  - DATA_W=32.
- Sub-module sysid_uptime_counter:
  - Contents: 64-bit counter, optional prescaler, lo/hi load, clear, hi snapshot capture.
  - Top level keeps address decode, scratch registers and the read pipeline.

Test Plan:
- Reset, then read addr 0 and addr 1 in consecutive cycles -> two consecutive valids with 0x58012555 then TIMESTAMP; readdatavalid is 0 in the read cycle itself.
- Write SCRATCH0=0xDEADBEEF with be=4'b0011, then read -> 0x0000BEEF; write be=4'b1100 0x12340000, then read -> 0x1234BEEF.
- Write HI=0, LO=0xFFFFFFFE, CTRL=1; wait 4 clocks, read LO then HI -> LO=0x00000002 or greater, HI=0x00000001 from the snapshot; an HI write after the LO read does not change the snapshot.
- Write CTRL=0 and hold 10 clocks -> two LO reads are equal. Write CTRL=3 -> next LO read is a small value (counted from 0).
- Read addr 7 -> 0x00000000; write addr 7 -> no register changes. Assert reset_n low during a read cycle -> no readdatavalid and all registers at reset values.
- With SYSID_PRESCALE_EN and PRESCALE_DIV=50: clear, then wait 500 clocks and read LO -> 10 (±1 tick).
